// File: rtl/envelope_sequencer_pkg.sv
// Shared audio definitions: phase codes, speed width and the lerper speed encoding.
`timescale 1ns/1ps
package envelope_sequencer_pkg;

    // Speed encoding shared with the lerper: positive N = N steps per cycle,
    // negative -N = 1 step every N cycles, 0 = immediate jump to target.
    localparam int SPEED_WIDTH = 16;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_ATTACK  = 3'd1;
    localparam logic [2:0] PH_HOLD    = 3'd2;
    localparam logic [2:0] PH_DECAY   = 3'd3;
    localparam logic [2:0] PH_SUSTAIN = 3'd4;
    localparam logic [2:0] PH_RELEASE = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = PH_IDLE,
        ST_ATTACK  = PH_ATTACK,
        ST_HOLD    = PH_HOLD,
        ST_DECAY   = PH_DECAY,
        ST_SUSTAIN = PH_SUSTAIN,
        ST_RELEASE = PH_RELEASE
    } state_t;

endpackage

// File: rtl/envelope_sequencer_hold_timer.sv
// Peak-hold down counter: load, decrement while above zero, zero flag. Never wraps.
`timescale 1ns/1ps
module hold_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/envelope_sequencer.sv
// Gated attack/hold/decay/sustain/release envelope driving one lerper voice.
`timescale 1ns/1ps
module envelope_sequencer
    import envelope_sequencer_pkg::*;
#(
    parameter int SIGNAL_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    gate,
    input  logic [SPEED_WIDTH-1:0]  attack_speed,
    input  logic [SPEED_WIDTH-1:0]  decay_speed,
    input  logic [SPEED_WIDTH-1:0]  release_speed,
    input  logic [SIGNAL_WIDTH-1:0] peak_level,
    input  logic [SIGNAL_WIDTH-1:0] sustain_level,
    input  logic [15:0]             hold_cycles,
    input  logic [SIGNAL_WIDTH-1:0] i_level,
    output logic [SIGNAL_WIDTH-1:0] o_target,
    output logic [SPEED_WIDTH-1:0]  o_speed,
    output logic [2:0]              o_phase,
    output logic                    o_active,
    output logic                    o_done
);

    state_t state;
    state_t next_state;
    logic   gate_q;
    logic   armed;
    logic   rise;
    logic   done_next;
    logic   hold_load;
    logic   hold_dec;
    logic   hold_zero;
    logic   peak_hit;

    // armed blocks a false rise when gate is already high as reset releases.
    assign rise     = gate & ~gate_q & armed;
    assign peak_hit = (i_level == peak_level);

    always_comb begin
        next_state = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE:    if (rise) next_state = ST_ATTACK;
            ST_ATTACK: begin
                if (!gate)         next_state = ST_RELEASE;
                else if (peak_hit) next_state = (hold_cycles == 16'd0) ? ST_DECAY : ST_HOLD;
            end
            ST_HOLD: begin
                if (!gate)          next_state = ST_RELEASE;
                else if (hold_zero) next_state = ST_DECAY;
            end
            ST_DECAY: begin
                if (!gate)                           next_state = ST_RELEASE;
                else if (i_level == sustain_level)   next_state = ST_SUSTAIN;
            end
            ST_SUSTAIN: if (!gate) next_state = ST_RELEASE;
            ST_RELEASE: begin
                if (rise) begin
                    next_state = ST_ATTACK;
                end else if (i_level == '0) begin
                    next_state = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    assign hold_load = (state == ST_ATTACK) && gate && peak_hit && (hold_cycles != 16'd0);
    assign hold_dec  = (state == ST_HOLD) && gate && !hold_zero;

    hold_timer #(.WIDTH(16)) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (hold_load),
        .load_value (hold_cycles - 16'd1),
        .dec        (hold_dec),
        .zero       (hold_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gate_q   <= 1'b0;
            armed    <= 1'b0;
            o_target <= '0;
            o_speed  <= '0;
            o_done   <= 1'b0;
        end else begin
            state  <= next_state;
            gate_q <= gate;
            armed  <= armed | ~gate;
            o_done <= done_next;
            case (next_state)
                ST_ATTACK:  begin o_target <= peak_level;    o_speed <= attack_speed;  end
                ST_HOLD:    begin o_target <= peak_level;    o_speed <= '0;            end
                ST_DECAY:   begin o_target <= sustain_level; o_speed <= decay_speed;   end
                ST_SUSTAIN: begin o_target <= sustain_level; o_speed <= decay_speed;   end
                ST_RELEASE: begin o_target <= '0;            o_speed <= release_speed; end
                default:    begin o_target <= '0;            o_speed <= '0;            end
            endcase
        end
    end

    assign o_phase  = state;
    assign o_active = (state != ST_IDLE);

endmodule

// File: tb/tb_envelope_sequencer.sv
// Scenario bench for envelope_sequencer with a small lerper model closing the level loop.
`timescale 1ns/1ps
module tb_envelope_sequencer;

    localparam int W = 37;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [15:0] attack_speed;
    logic [15:0] decay_speed;
    logic [15:0] release_speed;
    logic [15:0] peak_level;
    logic [15:0] sustain_level;
    logic [15:0] hold_cycles;
    logic [15:0] i_level;
    logic [15:0] o_target;
    logic [15:0] o_speed;
    logic [2:0]  o_phase;
    logic        o_active;
    logic        o_done;

    logic [W-1:0] exp_q[$];
    logic         stim_gate_q[$];
    logic         stim_rst_q[$];
    logic [W-1:0] exp_val;
    logic [W-1:0] obs_val;
    int           checks;
    int           errors;

    envelope_sequencer #(.SIGNAL_WIDTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .gate          (gate),
        .attack_speed  (attack_speed),
        .decay_speed   (decay_speed),
        .release_speed (release_speed),
        .peak_level    (peak_level),
        .sustain_level (sustain_level),
        .hold_cycles   (hold_cycles),
        .i_level       (i_level),
        .o_target      (o_target),
        .o_speed       (o_speed),
        .o_phase       (o_phase),
        .o_active      (o_active),
        .o_done        (o_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_dut();
        rst  = 1'b1;
        gate = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_level = 16'd0;
    endtask

    // Expected record: {phase, active, done, target, speed}
    function automatic logic [W-1:0] rec(input logic [2:0] ph, input logic dn,
                                         input logic [15:0] tg, input logic [15:0] sp);
        return {ph, (ph != 3'd0), dn, tg, sp};
    endfunction

    // Lerper model: one step toward target per cycle (negative speeds approximated as 1/cycle).
    function automatic logic [15:0] lerp(input logic [15:0] cur, input logic [15:0] tgt,
                                         input logic [15:0] spd);
        int c, t, s;
        c = int'(cur);
        t = int'(tgt);
        s = int'($signed(spd));
        if (s == 0) return tgt;
        if (s < 0) s = 1;
        if (c < t)      c = ((t - c) > s) ? c + s : t;
        else if (c > t) c = ((c - t) > s) ? c - s : t;
        return 16'(c);
    endfunction

    task automatic plan(input int n, input logic g, input logic r, input logic [W-1:0] e);
        repeat (n) begin
            stim_gate_q.push_back(g);
            stim_rst_q.push_back(r);
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        plan(1, 1'b0, 1'b1, rec(3'd0, 1'b0, 16'd0, 16'd0));
        plan(2, 1'b0, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
        end
    endtask

    task automatic test_adsr();
        reset_dut();
        peak_level = 16'd1000; sustain_level = 16'd400; hold_cycles = 16'd0;
        attack_speed = 16'd100; decay_speed = 16'd50; release_speed = 16'd200;
        plan(10, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd1000, 16'd100));
        plan(12, 1'b1, 1'b0, rec(3'd3, 1'b0, 16'd400, 16'd50));
        plan(3,  1'b1, 1'b0, rec(3'd4, 1'b0, 16'd400, 16'd50));
        plan(2,  1'b0, 1'b0, rec(3'd5, 1'b0, 16'd0, 16'd200));
        plan(1,  1'b0, 1'b0, rec(3'd0, 1'b1, 16'd0, 16'd0));
        plan(2,  1'b0, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL adsr cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_peak_hold();
        reset_dut();
        peak_level = 16'd1000; sustain_level = 16'd400; hold_cycles = 16'd5;
        attack_speed = 16'd500; release_speed = 16'd100;
        decay_speed = 16'($urandom_range(600, 2000));
        plan(2, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd1000, 16'd500));
        plan(5, 1'b1, 1'b0, rec(3'd2, 1'b0, 16'd1000, 16'd0));
        plan(1, 1'b1, 1'b0, rec(3'd3, 1'b0, 16'd400, decay_speed));
        plan(2, 1'b1, 1'b0, rec(3'd4, 1'b0, 16'd400, decay_speed));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL peak_hold cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_early_release();
        reset_dut();
        peak_level = 16'd1000; sustain_level = 16'd400; hold_cycles = 16'd0;
        attack_speed = 16'd100; decay_speed = 16'd50; release_speed = 16'd100;
        plan(3, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd1000, 16'd100));
        plan(3, 1'b0, 1'b0, rec(3'd5, 1'b0, 16'd0, 16'd100));
        plan(1, 1'b0, 1'b0, rec(3'd0, 1'b1, 16'd0, 16'd0));
        plan(1, 1'b0, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL early_release cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_retrigger();
        reset_dut();
        peak_level = 16'd600; sustain_level = 16'd600; hold_cycles = 16'd0;
        attack_speed = 16'd200; decay_speed = 16'd50; release_speed = 16'd200;
        plan(3, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd600, 16'd200));
        plan(1, 1'b1, 1'b0, rec(3'd3, 1'b0, 16'd600, 16'd50));
        plan(1, 1'b1, 1'b0, rec(3'd4, 1'b0, 16'd600, 16'd50));
        plan(2, 1'b0, 1'b0, rec(3'd5, 1'b0, 16'd0, 16'd200));
        plan(2, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd600, 16'd200));
        plan(1, 1'b1, 1'b0, rec(3'd3, 1'b0, 16'd600, 16'd50));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL retrigger cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_degenerate();
        reset_dut();
        i_level = 16'd500;
        peak_level = 16'd500; sustain_level = 16'd500; hold_cycles = 16'd0;
        attack_speed = 16'd100; decay_speed = 16'd70; release_speed = 16'd100;
        plan(1, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd500, 16'd100));
        plan(1, 1'b1, 1'b0, rec(3'd3, 1'b0, 16'd500, 16'd70));
        plan(2, 1'b1, 1'b0, rec(3'd4, 1'b0, 16'd500, 16'd70));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL degenerate cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_zero_peak();
        reset_dut();
        peak_level = 16'd0; sustain_level = 16'd300; hold_cycles = 16'd0;
        attack_speed = 16'd40; decay_speed = 16'd100; release_speed = 16'd100;
        plan(1, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd0, 16'd40));
        plan(3, 1'b1, 1'b0, rec(3'd3, 1'b0, 16'd300, 16'd100));
        plan(1, 1'b1, 1'b0, rec(3'd4, 1'b0, 16'd300, 16'd100));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL zero_peak cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_gate_pulse();
        reset_dut();
        peak_level = 16'd1000; sustain_level = 16'd400; hold_cycles = 16'd0;
        attack_speed = 16'd100; decay_speed = 16'd50; release_speed = 16'd100;
        plan(1, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd1000, 16'd100));
        plan(1, 1'b0, 1'b0, rec(3'd5, 1'b0, 16'd0, 16'd100));
        plan(1, 1'b0, 1'b0, rec(3'd0, 1'b1, 16'd0, 16'd0));
        plan(1, 1'b0, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL gate_pulse cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_gate_at_reset();
        peak_level = 16'd800; attack_speed = 16'd100; hold_cycles = 16'd0;
        i_level = 16'd0;
        plan(1, 1'b1, 1'b1, rec(3'd0, 1'b0, 16'd0, 16'd0));
        plan(3, 1'b1, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        plan(1, 1'b0, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        plan(1, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd800, 16'd100));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL gate_at_reset cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    task automatic test_reset_mid_hold();
        reset_dut();
        peak_level = 16'd1000; sustain_level = 16'd400; hold_cycles = 16'd5;
        attack_speed = 16'd500; decay_speed = 16'd100; release_speed = 16'd100;
        plan(2, 1'b1, 1'b0, rec(3'd1, 1'b0, 16'd1000, 16'd500));
        plan(2, 1'b1, 1'b0, rec(3'd2, 1'b0, 16'd1000, 16'd0));
        plan(1, 1'b1, 1'b1, rec(3'd0, 1'b0, 16'd0, 16'd0));
        plan(2, 1'b1, 1'b0, rec(3'd0, 1'b0, 16'd0, 16'd0));
        for (int cyc = 0; exp_q.size() > 0; cyc++) begin
            gate = stim_gate_q.pop_front();
            rst  = stim_rst_q.pop_front();
            @(posedge clk);
            @(negedge clk);
            exp_val = exp_q.pop_front();
            obs_val = {o_phase, o_active, o_done, o_target, o_speed};
            checks++;
            if (obs_val !== exp_val) begin
                errors++;
                $display("FAIL reset_mid_hold cyc %0d: got %h expected %h", cyc, obs_val, exp_val);
            end
            i_level = lerp(i_level, o_target, o_speed);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        gate = 1'b0;
        attack_speed = '0;
        decay_speed = '0;
        release_speed = '0;
        peak_level = '0;
        sustain_level = '0;
        hold_cycles = '0;
        i_level = '0;
        @(negedge clk);
        test_reset();
        test_adsr();
        test_peak_hold();
        test_early_release();
        test_retrigger();
        test_degenerate();
        test_zero_peak();
        test_gate_pulse();
        test_gate_at_reset();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
